// File: rtl/console_axis_pkg.sv
// Shared types for the console AXI-Stream packer and its word FIFO.
package console_axis_pkg;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = BYTE_W * LANES;
  localparam int LANE_W = $clog2(LANES);

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [LANES-1:0]  keep;
    logic              last;
  } beat_t;

  typedef enum logic {
    ST_PACK       = 1'b0,
    ST_FLUSH_WAIT = 1'b1
  } pack_state_t;

endpackage

// File: rtl/axis_word_fifo.sv
// Synchronous FIFO of beat structs; the occupancy counter is the single
// source of full/empty, pointers wrap modulo DEPTH.
module axis_word_fifo
  import console_axis_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  beat_t            push_beat,
  input  logic             pop,
  output beat_t            head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  beat_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A pop frees the slot this push lands in, so full plus pop is legal.
  assign do_push = push && (!full || do_pop);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the occupancy count says what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_beat;
  end

endmodule

// File: rtl/console_axis_packer.sv
// Packs the console byte stream little-endian into 32-bit AXI-Stream words
// for the DMA S2MM channel, with an idle timeout that closes partial words.
module console_axis_packer
  import console_axis_pkg::*;
#(
  parameter  int OUT_DEPTH     = 4,
  parameter  int FLUSH_TIMEOUT = 1024,
  parameter  int CNT_W         = 16,
  localparam int PEND_W        = $clog2(OUT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              s_tready,
  input  logic              s_tvalid,
  input  logic [7:0]        s_tdata,
  input  logic              s_tlast,
  output logic [31:0]       m_axis_tdata,
  output logic [3:0]        m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [PEND_W-1:0] words_pending,
  output logic [CNT_W-1:0]  bytes_accepted,
  output logic              overflow
);

  localparam bit               FLUSH_EN   = (FLUSH_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);

  pack_state_t       state_q, state_d;
  logic [WORD_W-1:0] asm_data_q, asm_data_d;
  logic [LANES-1:0]  asm_keep_q, asm_keep_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  bytes_q, bytes_d;
  logic              overflow_q, overflow_d;

  logic              fifo_push, fifo_full, fifo_empty;
  beat_t             push_beat, head;
  logic [PEND_W-1:0] fifo_count;
  logic              would_push, drop, accept, flush_due;
  logic [WORD_W-1:0] merged_data;
  logic [LANES-1:0]  merged_keep;

  axis_word_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_beat (push_beat),
    .pop       (m_axis_tready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    would_push = (lane_q == LANE_W'(LANES - 1)) || s_tlast;
    drop       = s_tvalid && would_push && fifo_full;
    accept     = s_tvalid && !drop;
    flush_due  = FLUSH_EN && (lane_q != '0) &&
                 ((state_q == ST_FLUSH_WAIT) || (timer_q == FLUSH_LAST));

    merged_data = asm_data_q;
    merged_data[lane_q * BYTE_W +: BYTE_W] = s_tdata;
    merged_keep = asm_keep_q;
    merged_keep[lane_q] = 1'b1;

    state_d    = state_q;
    asm_data_d = asm_data_q;
    asm_keep_d = asm_keep_q;
    lane_d     = lane_q;
    timer_d    = timer_q;
    bytes_d    = bytes_q;
    overflow_d = overflow_q;
    fifo_push  = 1'b0;
    push_beat  = '0;

    if (accept) begin
      // An accepted byte always cancels a pending or due flush.
      bytes_d = bytes_q + 1'b1;
      timer_d = '0;
      state_d = ST_PACK;
      if (would_push) begin
        fifo_push  = 1'b1;
        push_beat  = '{data: merged_data, keep: merged_keep, last: s_tlast};
        asm_data_d = '0;
        asm_keep_d = '0;
        lane_d     = '0;
      end else begin
        asm_data_d = merged_data;
        asm_keep_d = merged_keep;
        lane_d     = lane_q + 1'b1;
      end
    end else begin
      if (drop) overflow_d = 1'b1;
      if (flush_due) begin
        if (!fifo_full) begin
          fifo_push  = 1'b1;
          push_beat  = '{data: asm_data_q, keep: asm_keep_q, last: 1'b1};
          asm_data_d = '0;
          asm_keep_d = '0;
          lane_d     = '0;
          timer_d    = '0;
          state_d    = ST_PACK;
        end else begin
          state_d = ST_FLUSH_WAIT;
        end
      end else if (FLUSH_EN && (lane_q != '0)) begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_PACK;
      asm_data_q <= '0;
      asm_keep_q <= '0;
      lane_q     <= '0;
      timer_q    <= '0;
      bytes_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      asm_data_q <= asm_data_d;
      asm_keep_q <= asm_keep_d;
      lane_q     <= lane_d;
      timer_q    <= timer_d;
      bytes_q    <= bytes_d;
      overflow_q <= overflow_d;
    end
  end

  // Two free slots cover the byte already requested in the previous cycle.
  assign s_tready       = !rst && (fifo_count <= PEND_W'(OUT_DEPTH - 2));
  assign m_axis_tvalid  = !fifo_empty;
  assign m_axis_tdata   = fifo_empty ? '0 : head.data;
  assign m_axis_tkeep   = fifo_empty ? '0 : head.keep;
  assign m_axis_tlast   = !fifo_empty && head.last;
  assign words_pending  = fifo_count;
  assign bytes_accepted = bytes_q;
  assign overflow       = overflow_q;

endmodule

// File: doc/console_axis_packer.md
Name: console_axis_packer

Overview:
- Sits directly downstream of the console output byte FIFO stage.
- Consumes its one-byte-per-beat stream: the byte and its tlast flag arrive one cycle after the packer raises tready.
- Packs bytes little-endian into 32-bit AXI-Stream words with tkeep/tlast for the DMA S2MM channel.
- Buffers words in a small FIFO so DMA backpressure never drops a character, and flushes stale partial words on an idle timeout.

Parameters:
- OUT_DEPTH, 4, word FIFO depth in 32-bit words; must be >= 2.
- FLUSH_TIMEOUT, 1024, idle cycles before a non-empty partial word is force-closed with tlast=1; 0 disables the timeout.
- CNT_W, 16, width of the idle timer and the accepted-byte counter.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- s_tready  out  1  to the upstream stage's tready; requests one byte, which arrives next cycle.
- s_tvalid  in  1  upstream byte valid (one cycle after the request).
- s_tdata  in  8  upstream byte.
- s_tlast  in  1  upstream end-of-transfer marker.
- m_axis_tdata  out  32  packed word; first byte in [7:0].
- m_axis_tkeep  out  4  valid byte lanes; contiguous from lane 0.
- m_axis_tlast  out  1  last beat of a DMA transfer.
- m_axis_tvalid  out  1  word available.
- m_axis_tready  in  1  DMA accepts the word.
- words_pending  out  $clog2(OUT_DEPTH+1)  current word FIFO occupancy.
- bytes_accepted  out  CNT_W  wrapping count of bytes accepted since reset.
- overflow  out  1  sticky flag: s_tvalid arrived with no room; the byte was dropped.

Behaviour:
- Reset (synchronous, rst=1 at posedge): all outputs are 0, the FIFO is emptied, the assembly register and lane index are cleared, and the timer is cleared. Reset overrides every other event in the same cycle.
- s_tready = !rst && (words_pending <= OUT_DEPTH-2), combinational from registered occupancy. Because of the one-cycle upstream latency, this guarantees a FIFO slot for any in-flight byte.
- Accepting a byte (s_tvalid=1 and a slot is available):
  - Write s_tdata into lane lane_idx of the assembly register and set that tkeep bit.
  - Increment lane_idx and bytes_accepted (the counter wraps).
  - If lane_idx was 3 or s_tlast=1, push {data, keep, s_tlast} to the FIFO at this same edge and clear the assembly register. Latency from byte arrival to m_axis_tvalid is 1 cycle.
  - A tlast byte in lane 0 yields tkeep=4'b0001 and tlast=1.
- Drop: if s_tvalid=1 while the FIFO is full and the assembly would push, discard the byte, leave the assembly register unchanged, and set overflow=1 until rst.
- Idle flush: when FLUSH_TIMEOUT != 0 and lane_idx != 0, the timer counts cycles without an accepted byte and resets on every accept.
  - When the timer reaches FLUSH_TIMEOUT and the FIFO is not full, push the partial word with tlast=1, clear the assembly register, and clear the timer.
  - If the FIFO is full, hold and retry each cycle.
  - An accept arriving in the same cycle as the timeout wins; the flush is cancelled that cycle.
- Output side: a standard AXIS hold rule applies. tdata, tkeep and tlast are stable while tvalid=1 and tready=0. A pop happens when tvalid && tready.
  - Simultaneous push and pop leaves the occupancy unchanged. Pop from a full FIFO plus push in the same cycle is legal.
- Word FIFO: read and write pointers wrap modulo OUT_DEPTH; the occupancy counter is the source of full/empty.
- States (2): PACK (normal operation) and FLUSH_WAIT (timeout expired, FIFO full). FLUSH_WAIT returns to PACK on push or on an accepted byte.

Decomposition:
- Shared package (console_axis_pkg):
  - BYTE_W=8 and LANES=4.
  - Word beat struct {data[31:0], keep[3:0], last}.
  - Packer state enum.
- Sub-module: axis_word_fifo.
  - Synchronous FIFO of beat structs with parameter DEPTH.
  - Ports: push, pop, full, empty, count.
  - Reused later for the input-side unpacker.

Test Plan:
- Steady transfer: after reset, tready held; bytes 0x41,0x42,0x43,0x44 (last on 0x44) -> one beat, tdata=0x44434241, tkeep=4'hF, tlast=1, tvalid 1 cycle after the 4th byte; bytes_accepted=4.
- Partial word: bytes 0x61,0x62 with last on 0x62 -> tdata[15:0]=0x6261, tkeep=4'b0011, tlast=1.
- Backpressure (OUT_DEPTH=4): m_axis_tready=0, stream 20 bytes -> s_tready drops when words_pending=3; words_pending never exceeds 4; overflow stays 0; after release all 20 bytes emerge in order.
- Idle flush (FLUSH_TIMEOUT=8): single byte 0x7A, no last -> beat tdata[7:0]=0x7A, tkeep=4'b0001, tlast=1 exactly 8 cycles after the accept; with FLUSH_TIMEOUT=0, no beat appears within 2000 cycles.
- Forced overflow: FIFO full, drive s_tvalid=1 ignoring s_tready -> byte dropped, overflow=1 sticky, FIFO contents unchanged.
- Reset mid-stream: rst=1 for 1 cycle with 2 words queued and 3 bytes assembled -> next cycle tvalid=0, words_pending=0, bytes_accepted=0, overflow=0; the next 4-byte packet packs from lane 0.
